// File: rtl/cipher_frame_pkg.sv
// Shared types and defaults for the cipher frame controller.
// Optional feature macro used by the controller: CIPHER_FRAME_PARITY_EN.
package cipher_frame_pkg;

  localparam int MSG_W_DEF  = 64;
  localparam int SEED_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The keystream generator advances in every state where this is true.
  function automatic logic is_shift_state(input state_t s);
    return (s == LOAD) || (s == RUN);
  endfunction

endpackage

// File: rtl/cipher_frame_ctrl.sv
// Frame controller: loads a keystream seed, XORs one message bit per cycle MSB-first
// with the keystream bit, and hands the result over a valid/ready handshake.
// Define CIPHER_FRAME_PARITY_EN to add the serially accumulated out_parity port.
module cipher_frame_ctrl
  import cipher_frame_pkg::*;
#(
  parameter int MSG_W  = MSG_W_DEF,
  parameter int SEED_W = SEED_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MSG_W-1:0]  in_msg,
  input  logic [SEED_W-1:0] in_seed,
  output logic              ks_load,
  output logic              ks_shift,
  output logic [SEED_W-1:0] ks_seed,
  input  logic              ks_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MSG_W-1:0]  out_msg,
  output logic              busy
`ifdef CIPHER_FRAME_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  localparam int IDX_W = $clog2(MSG_W);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [MSG_W-1:0]   r_msg;
  logic [MSG_W-1:0]   r_out;
  logic [SEED_W-1:0]  r_seed;
  logic               w_accept;
  logic               w_bit;

  logic r_in_ready, r_out_valid, r_busy, r_ks_load, r_ks_shift;
  logic w_in_ready_nxt, w_out_valid_nxt, w_busy_nxt, w_ks_load_nxt, w_ks_shift_nxt;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_bit    = r_msg[r_idx] ^ ks_bit;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)      w_state_nxt = LOAD;
      LOAD:                       w_state_nxt = RUN;
      RUN:     if (r_idx == '0)   w_state_nxt = DONE;
      DONE:    if (out_ready)     w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state and never depend combinationally on inputs.
  always_comb begin
    w_in_ready_nxt  = (w_state_nxt == IDLE);
    w_busy_nxt      = (w_state_nxt != IDLE);
    w_out_valid_nxt = (w_state_nxt == DONE);
    w_ks_load_nxt   = (w_state_nxt == LOAD);
    w_ks_shift_nxt  = is_shift_state(w_state_nxt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_ks_load   <= 1'b0;
      r_ks_shift  <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_ks_load   <= w_ks_load_nxt;
      r_ks_shift  <= w_ks_shift_nxt;
    end
  end

  // Request capture, bit index and serial XOR result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_msg  <= '0;
      r_seed <= '0;
      r_idx  <= '0;
      r_out  <= '0;
    end else begin
      if (w_accept) begin
        r_msg  <= in_msg;
        r_seed <= in_seed;
      end
      if (r_state == LOAD) begin
        r_idx <= IDX_W'(MSG_W - 1);
      end else if ((r_state == RUN) && (r_idx != '0)) begin
        r_idx <= r_idx - 1'b1;
      end
      if (r_state == RUN) begin
        r_out[r_idx] <= w_bit;
      end
    end
  end

`ifdef CIPHER_FRAME_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity <= 1'b0;
    end else if (r_state == LOAD) begin
      r_parity <= 1'b0;
    end else if (r_state == RUN) begin
      r_parity <= r_parity ^ w_bit;
    end
  end

  assign out_parity = r_parity;
`endif

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign ks_load   = r_ks_load;
  assign ks_shift  = r_ks_shift;
  assign ks_seed   = r_seed;
  assign out_msg   = r_out;

endmodule

// File: tb/tb_cipher_frame_ctrl.sv
// Self-checking bench for cipher_frame_ctrl with a behavioural keystream generator
// and a word-level reference model (msg XOR keystream word).
module tb_cipher_frame_ctrl;

  localparam int MSG_W  = 64;
  localparam int SEED_W = 8;
  localparam logic [63:0] ISL = 64'h49534C2055464D47;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [MSG_W-1:0]  in_msg;
  logic [SEED_W-1:0] in_seed;
  logic              ks_load;
  logic              ks_shift;
  logic [SEED_W-1:0] ks_seed;
  logic              ks_bit;
  logic              out_valid;
  logic              out_ready;
  logic [MSG_W-1:0]  out_msg;
  logic              busy;
`ifdef CIPHER_FRAME_PARITY_EN
  logic              out_parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int ks_mode;              // 0: tied low, 1: tied high, 2: generator
  logic [7:0] gen_lfsr;
  int n_load, n_shift, n_bad;

  cipher_frame_ctrl #(.MSG_W(MSG_W), .SEED_W(SEED_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_msg    (in_msg),
    .in_seed   (in_seed),
    .ks_load   (ks_load),
    .ks_shift  (ks_shift),
    .ks_seed   (ks_seed),
    .ks_bit    (ks_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_msg   (out_msg),
    .busy      (busy)
`ifdef CIPHER_FRAME_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Stand-in for the streamcipher generator: registered output bit.
  always @(posedge clk or negedge reset) begin
    if (!reset)        gen_lfsr <= '0;
    else if (ks_load)  gen_lfsr <= ks_seed;
    else if (ks_shift) gen_lfsr <= lfsr_step(gen_lfsr);
  end

  always_comb begin
    ks_bit = 1'b0;
    if (ks_mode == 1)      ks_bit = 1'b1;
    else if (ks_mode == 2) ks_bit = gen_lfsr[0];
  end

  always @(negedge clk) begin
    if (ks_load)           n_load  <= n_load + 1;
    if (ks_shift)          n_shift <= n_shift + 1;
    if (busy && in_ready)  n_bad   <= n_bad + 1;
  end

  // Keystream word as the message sees it: the seed's bit 0 meets the MSB,
  // then one generator step per following bit.
  function automatic logic [63:0] ks_word(input logic [7:0] seed);
    logic [7:0]  l;
    logic [63:0] w;
    l = seed;
    w = '0;
    for (int k = 0; k < MSG_W; k++) begin
      w[MSG_W-1-k] = l[0];
      l = lfsr_step(l);
    end
    return w;
  endfunction

  function automatic logic [63:0] ref_result(input logic [63:0] msg, input logic [7:0] seed,
                                             input int mode);
    if (mode == 0) return msg;
    if (mode == 1) return ~msg;
    return msg ^ ks_word(seed);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with the block idle.
  task automatic run_frame(input logic [63:0] msg, input logic [7:0] seed, input int mode,
                           input int hold, input bit raise_next, output logic [63:0] res);
    int n;
    bit stable;
    logic [63:0] exp;
    exp = ref_result(msg, seed, mode);
    ks_mode  = mode;
    in_msg   = msg;
    in_seed  = seed;
    in_valid = 1'b1;
    n_load = 0; n_shift = 0; n_bad = 0;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    check("ks_seed_load", 64'(ks_seed), 64'(seed));
    check("ks_load_in_load", 64'(ks_load), 64'd1);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd66);
    res = out_msg;
    check("result", res, exp);
`ifdef CIPHER_FRAME_PARITY_EN
    check("parity", 64'(out_parity), 64'(^exp));
`endif
    check("ks_load_cycles", 64'(n_load), 64'd1);
    check("ks_shift_cycles", 64'(n_shift), 64'd65);
    check("ready_while_busy", 64'(n_bad), 64'd0);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      stable &= (out_valid === 1'b1) && (out_msg === exp) && (ks_shift === 1'b0);
    end
    check("hold_stable", 64'(stable), 64'd1);
    check("ks_seed_hold", 64'(ks_seed), 64'(seed));
    out_ready = 1'b1;
    in_valid  = raise_next;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("released_valid", 64'(out_valid), 64'd0);
    check("released_idle", 64'({busy, in_ready}), 64'b01);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ks_ctl"}, 64'({ks_load, ks_shift}), 64'd0);
    check({tag, "_ks_seed"}, 64'(ks_seed), 64'd0);
    check({tag, "_out_msg"}, out_msg, 64'd0);
`ifdef CIPHER_FRAME_PARITY_EN
    check({tag, "_parity"}, 64'(out_parity), 64'd0);
`endif
  endtask

  initial begin
    logic [63:0] res, ct, msg;
    logic [7:0]  seed;
    bit          seen;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_msg = '0; in_seed = '0; ks_mode = 0;
    n_load = 0; n_shift = 0; n_bad = 0;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;
    @(negedge clk);

    run_frame(ISL, 8'h00, 0, 10, 1'b0, res);
    run_frame(ISL, 8'h5A, 1, 3, 1'b0, res);
    check("ones_vector", res, 64'hB6ACB3DFAAB9B2B8);

    run_frame(ISL, 8'hF0, 2, 0, 1'b0, ct);
    check("ct_differs", 64'(ct != ISL), 64'd1);
    run_frame(ct, 8'hF0, 2, 2, 1'b0, res);
    check("round_trip", res, ISL);

    for (int i = 0; i < 6; i++) begin
      msg  = {$urandom, $urandom};
      seed = 8'($urandom);
      run_frame(msg, seed, int'($urandom_range(0, 2)), int'($urandom_range(0, 10)),
                (i == 2), res);
    end

    // Abort in the middle of RUN.
    ks_mode = 2;
    in_msg = {$urandom, $urandom};
    in_seed = 8'hC3;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_in_run", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_values("abort");
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    run_frame(ISL, 8'hF0, 2, 1, 1'b0, res);
    check("after_abort", res, ct);

    run_frame(64'h7, 8'h11, 0, 0, 1'b0, res);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cipher_frame_ctrl.md
# cipher_frame_ctrl

Frame controller that sits directly in front of the `streamcipher` keystream generator and consumes its keystream bit. It accepts a whole message word plus seed over a valid/ready handshake, and loads the seed into the generator. It then XORs the message MSB-first with one keystream bit per cycle and presents the resulting word over a second valid/ready handshake. The same block serves for both encryption and decryption: re-running a ciphertext with the same seed returns the plaintext.

## Interface
- `MSG_W`, default 64: message width in bits, at least 2.
- `SEED_W`, default 8: keystream seed width.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: request present.
- `in_ready` output, 1 bit: block can accept a request.
- `in_msg` input, MSG_W bits: plaintext or ciphertext word.
- `in_seed` input, SEED_W bits: keystream seed for this frame.
- `ks_load` output, 1 bit: drives the generator's `loadControl`.
- `ks_shift` output, 1 bit: drives the generator's `shiftControl`.
- `ks_seed` output, SEED_W bits: drives the generator's `dataInput`.
- `ks_bit` input, 1 bit: generator's `dataShifted` keystream bit.
- `out_valid` output, 1 bit: result word valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_msg` output, MSG_W bits: XOR result.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch `in_msg` and `in_seed`, then go to LOAD.
- LOAD, exactly 1 cycle:
  - `ks_load`=1, `ks_shift`=1, `ks_seed`=latched seed.
  - Bit index is set to MSG_W-1, then go to RUN.
- RUN, exactly MSG_W cycles:
  - `ks_load`=0, `ks_shift`=1.
  - Each rising edge: `out_msg[idx] <= msg[idx] ^ ks_bit`, then idx decrements.
  - After the edge with idx==0, go to DONE. Index decrement never wraps.
- DONE:
  - `out_valid`=1 and `out_msg` is held stable.
  - `ks_shift`=0, so the keystream is frozen.
  - On `out_ready`, go to IDLE.
- `ks_seed` holds the last latched seed in every state.
- New requests are not accepted while `busy`; `in_ready`=0 outside IDLE.
- `in_valid` asserted in the same cycle that DONE completes is not accepted until the next IDLE cycle. There is no back-to-back bypass.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `ks_load`=0, `ks_shift`=0.
  - `ks_seed`=0, `out_msg`=0.
- Reset asserted mid-frame aborts immediately. The partial result is discarded, and no `out_valid` pulse is produced.
- Latency, accept edge to first `out_valid` cycle: 1 (LOAD) + MSG_W (RUN) + 1 cycles. This is 66 cycles for MSG_W=64.
- Throughput: one frame per MSG_W+3 cycles when `out_ready` is tied high.
- `ks_bit` is sampled on the same rising edge that advances the generator. The generator output is registered, so no combinational path exists from `ks_bit` to any output.
- All outputs are registered.

## Configuration
- `CIPHER_FRAME_PARITY_EN` defined:
  - Adds output `out_parity` (1 bit) = XOR of all `out_msg` bits, accumulated serially during RUN.
  - `out_parity` is valid with `out_valid`, and its reset value is 0.
- `CIPHER_FRAME_PARITY_EN` undefined: the port and its accumulator are absent, and behaviour is otherwise identical.

## Structure
- Shared package `cipher_frame_pkg` holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - default constants `MSG_W_DEF`=64 and `SEED_W_DEF`=8.
- No sub-module is needed. The FSM, index counter and result register live in one module.
- The keystream generator is instantiated beside this block at the parent level, not inside it.

## Test plan
- `ks_bit` tied 0, `in_msg`=0x49534C2055464D47 -> `out_msg`=0x49534C2055464D47, with `out_valid` on cycle 66 after acceptance.
- `ks_bit` tied 1, same message -> `out_msg`=0xB6ACB3DFAAB9B2B8.
- Round trip with generator attached, seed 0xF0, "ISL UFMG" -> ciphertext ≠ plaintext, and re-running with seed 0xF0 returns 0x49534C2055464D47.
- Protocol checks:
  - `ks_load` is high for exactly 1 cycle.
  - `ks_shift` is high for exactly 65 cycles per frame.
  - `in_ready`=0 while busy.
  - `out_valid` holds for 10 cycles with `out_ready`=0, and `out_msg` stays stable.
- Reset (low) asserted on RUN cycle 20 -> all outputs return to reset values at once, and the next frame completes correctly.
- With `CIPHER_FRAME_PARITY_EN`, `ks_bit`=0, `in_msg`=0x0000000000000007 -> `out_parity`=1.
